// File: rtl/multiport_switch_requester.sv
// Egress requester: pops one sideband entry per frame, requests the switch on a
// tdest-tagged stream, forwards 16-bit frame words, retries timed-out requests
// and discards frames that cannot or should not be delivered.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a sideband entry
// POP      | sideband_ren pulse; entry appears on sideband_rdata next cycle
// READ_SB  | latch end_ptr/dest, decide deliver or discard
// REQUEST  | first word offered, stall timer running
// BACKOFF  | tvalid low for BACKOFF_CYCLES before reissuing the request
// STREAM   | grant held, remaining words forwarded, no timeout
// SKIP     | rewind frame FIFO read pointer to end_ptr, count the drop
module multiport_switch_requester #(
  parameter int ADDR_WIDTH        = 11,
  parameter int NUM_PORTS         = 4,
  parameter int DEST_WIDTH        = 2,
  parameter int TIMEOUT_CTR_WIDTH = 9,
  parameter int MAX_RETRIES       = 3,
  parameter int BACKOFF_CYCLES    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               port_enable,
  input  logic [ADDR_WIDTH+DEST_WIDTH+1:0]   sideband_rdata,
  input  logic                               sideband_empty,
  output logic                               sideband_ren,
  input  logic [15:0]                        frame_rdata,
  input  logic [ADDR_WIDTH:0]                frame_rptr,
  output logic                               frame_ren,
  output logic                               frame_rrst,
  output logic [ADDR_WIDTH:0]                frame_rst_rptr,
  output logic [15:0]                        egress_tdata,
  output logic [DEST_WIDTH-1:0]              egress_tdest,
  output logic                               egress_tvalid,
  output logic                               egress_tlast,
  input  logic                               egress_tready,
  output logic [15:0]                        frames_sent,
  output logic [15:0]                        frames_dropped
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int EW = 2 ** DEST_WIDTH;
  localparam logic [BW-1:0]                BACKOFF_LOAD = BW'(BACKOFF_CYCLES - 1);
  localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_LOAD   = '1;

  typedef enum logic [2:0] {IDLE, POP, READ_SB, REQUEST, BACKOFF, STREAM, SKIP} state_t;

  state_t                       state_q, state_d;
  logic [PW-1:0]                end_ptr_q;
  logic [DEST_WIDTH-1:0]        dest_q;
  logic [RW-1:0]                retry_q;
  logic [TIMEOUT_CTR_WIDTH-1:0] stall_q;
  logic [BW-1:0]                backoff_q;
  logic [15:0]                  sent_q, dropped_q;

  logic [PW-1:0]         sb_end;
  logic [DEST_WIDTH-1:0] sb_dest;
  logic                  sb_drop;
  logic [EW-1:0]         port_en_ext;
  logic                  skip_frame, retry_ok, is_last;
  logic [PW-1:0]         rptr_next;
  logic                  sb_ren_c, tvalid_c, rrst_c;

  assign sb_end      = sideband_rdata[PW-1:0];
  assign sb_dest     = sideband_rdata[PW +: DEST_WIDTH];
  assign sb_drop     = sideband_rdata[PW+DEST_WIDTH];
  assign port_en_ext = EW'(port_enable);
  assign skip_frame  = sb_drop | ~port_en_ext[sb_dest] | (frame_rptr == sb_end)
                     | (int'(sb_dest) >= NUM_PORTS);
  assign retry_ok    = int'(retry_q) < MAX_RETRIES;
  // Pointer math wraps naturally at PW bits, covering frames that straddle the FIFO end.
  assign rptr_next   = frame_rptr + PW'(1);
  assign is_last     = (rptr_next == end_ptr_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d  = state_q;
    sb_ren_c = 1'b0;
    tvalid_c = 1'b0;
    rrst_c   = 1'b0;
    case (state_q)
      IDLE:    if (!sideband_empty) state_d = POP;
      POP: begin
        sb_ren_c = 1'b1;
        state_d  = READ_SB;
      end
      READ_SB: state_d = skip_frame ? SKIP : REQUEST;
      REQUEST: begin
        tvalid_c = 1'b1;
        if (egress_tready)        state_d = is_last ? IDLE : STREAM;
        else if (stall_q == '0)   state_d = retry_ok ? BACKOFF : SKIP;
      end
      BACKOFF: if (backoff_q == '0) state_d = REQUEST;
      STREAM: begin
        tvalid_c = 1'b1;
        if (egress_tready && is_last) state_d = IDLE;
      end
      SKIP: begin
        rrst_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame context, stall/backoff down-counters, retry count and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      end_ptr_q <= '0;
      dest_q    <= '0;
      retry_q   <= '0;
      stall_q   <= '0;
      backoff_q <= '0;
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      case (state_q)
        READ_SB: begin
          end_ptr_q <= sb_end;
          dest_q    <= sb_dest;
          retry_q   <= '0;
          stall_q   <= STALL_LOAD;
        end
        REQUEST: begin
          if (!egress_tready) begin
            if (stall_q == '0) begin
              backoff_q <= BACKOFF_LOAD;
              if (retry_ok) retry_q <= retry_q + RW'(1);
            end else begin
              stall_q <= stall_q - TIMEOUT_CTR_WIDTH'(1);
            end
          end
        end
        BACKOFF: begin
          if (backoff_q == '0) stall_q   <= STALL_LOAD;
          else                 backoff_q <= backoff_q - BW'(1);
        end
        default: ;
      endcase
      if (tvalid_c && egress_tready && is_last && sent_q != '1) sent_q <= sent_q + 16'd1;
      if (state_q == SKIP && dropped_q != '1) dropped_q <= dropped_q + 16'd1;
    end
  end

  // Every output is forced low while reset is high, including the first reset cycle.
  assign egress_tvalid  = tvalid_c & ~reset;
  assign frame_ren      = egress_tvalid & egress_tready;
  assign egress_tdata   = egress_tvalid ? frame_rdata : '0;
  assign egress_tlast   = egress_tvalid & is_last;
  assign egress_tdest   = reset ? '0 : dest_q;
  assign sideband_ren   = sb_ren_c & ~reset;
  assign frame_rrst     = rrst_c & ~reset;
  assign frame_rst_rptr = frame_rrst ? end_ptr_q : '0;
  assign frames_sent    = reset ? '0 : sent_q;
  assign frames_dropped = reset ? '0 : dropped_q;

endmodule

// File: tb/tb_multiport_switch_requester.sv
// Bench for multiport_switch_requester: models the frame/sideband FIFOs and
// predicts each frame's fate (delivered words or rewind pointer) from its
// sideband entry and the port enables.
module tb_multiport_switch_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  port_enable;
  logic [14:0] sideband_rdata;
  logic        sideband_empty, sideband_ren;
  logic [15:0] frame_rdata;
  logic [11:0] frame_rptr;
  logic        frame_ren, frame_rrst;
  logic [11:0] frame_rst_rptr;
  logic [15:0] egress_tdata;
  logic [1:0]  egress_tdest;
  logic        egress_tvalid, egress_tlast, egress_tready;
  logic [15:0] frames_sent, frames_dropped;

  always #5 clk = ~clk;

  multiport_switch_requester dut (
    .clk(clk), .reset(reset), .port_enable(port_enable),
    .sideband_rdata(sideband_rdata), .sideband_empty(sideband_empty), .sideband_ren(sideband_ren),
    .frame_rdata(frame_rdata), .frame_rptr(frame_rptr), .frame_ren(frame_ren),
    .frame_rrst(frame_rrst), .frame_rst_rptr(frame_rst_rptr),
    .egress_tdata(egress_tdata), .egress_tdest(egress_tdest), .egress_tvalid(egress_tvalid),
    .egress_tlast(egress_tlast), .egress_tready(egress_tready),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );

  // FIFO models
  logic [15:0] mem [0:4095];
  logic [14:0] sb_mem [0:255];
  int          sb_wr = 0;
  int          sb_rd = 0;
  logic        tb_load;
  logic [11:0] tb_load_val;
  logic [11:0] wptr;

  assign frame_rdata    = mem[frame_rptr];
  assign sideband_empty = (sb_rd == sb_wr);

  // Frame read pointer and sideband pop, as the FIFOs would behave.
  always @(posedge clk) begin
    if (tb_load)         frame_rptr <= tb_load_val;
    else if (frame_rrst) frame_rptr <= frame_rst_rptr;
    else if (frame_ren)  frame_rptr <= frame_rptr + 12'd1;
    if (sideband_ren) begin
      sideband_rdata <= sb_mem[sb_rd[7:0]];
      sb_rd          <= sb_rd + 1;
    end
  end

  // Expected delivery stream and expected rewinds
  logic [15:0] exp_data [0:2047];
  logic [1:0]  exp_dest [0:2047];
  logic        exp_last [0:2047];
  int          exp_wr = 0, exp_rd = 0;
  logic [11:0] drop_ptr [0:255];
  int          drop_wr = 0, drop_rd = 0;
  int          exp_sent = 0, exp_dropped = 0;
  bit          mon_data_en = 1'b1;
  int          checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // A frame is discarded if flagged, aimed at a disabled port, empty, or forced (timeout case).
  task automatic push_frame(input int len, input logic [1:0] dest, input logic drop, input bit force_drop);
    logic [15:0] w;
    bit dropped;
    dropped = drop || !port_enable[dest] || (len == 0) || force_drop;
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      mem[wptr] = w;
      if (!dropped) begin
        exp_data[exp_wr[10:0]] = w;
        exp_dest[exp_wr[10:0]] = dest;
        exp_last[exp_wr[10:0]] = (i == len - 1);
        exp_wr++;
      end
      wptr = wptr + 12'd1;
    end
    if (dropped) begin
      drop_ptr[drop_wr[7:0]] = wptr;
      drop_wr++;
      exp_dropped++;
    end else begin
      exp_sent++;
    end
    sb_mem[sb_wr[7:0]] = {drop, dest, wptr};
    sb_wr++;
  endtask

  task automatic drain(input bit rand_ready);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      egress_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sb_rd == sb_wr && exp_rd == exp_wr && drop_rd == drop_wr) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
    egress_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("frames_sent", 32'(frames_sent), 32'(exp_sent));
    chk("frames_dropped", 32'(frames_dropped), 32'(exp_dropped));
  endtask

  // Beat/rewind monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_rd  = exp_wr;
      drop_rd = drop_wr;
    end else begin
      chk("frame_ren", 32'(frame_ren), 32'(egress_tvalid & egress_tready));
      if (egress_tvalid && mon_data_en) begin
        if (exp_rd == exp_wr) begin
          chk("unexpected_beat", 32'(egress_tvalid), 32'd0);
        end else begin
          chk("tdata", 32'(egress_tdata), 32'(exp_data[exp_rd[10:0]]));
          chk("tdest", 32'(egress_tdest), 32'(exp_dest[exp_rd[10:0]]));
          chk("tlast", 32'(egress_tlast), 32'(exp_last[exp_rd[10:0]]));
          if (egress_tready) exp_rd = exp_rd + 1;
        end
      end
      if (frame_rrst) begin
        if (drop_rd == drop_wr) begin
          chk("unexpected_rrst", 32'(frame_rrst), 32'd0);
        end else begin
          chk("rst_rptr", 32'(frame_rst_rptr), 32'(drop_ptr[drop_rd[7:0]]));
          drop_rd = drop_rd + 1;
        end
      end
    end
  end

  initial begin
    int  n, ren_cnt, gap, runs, run_len, target;
    bit  seen_last, prev, got_rrst;
    reset = 1'b1; port_enable = 4'hF; egress_tready = 1'b0;
    tb_load = 1'b1; tb_load_val = 12'd0; wptr = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(egress_tvalid), 32'd0);
    chk("rst_sb_ren", 32'(sideband_ren), 32'd0);
    chk("rst_rrst", 32'(frame_rrst), 32'd0);
    chk("rst_sent", 32'(frames_sent), 32'd0);
    chk("rst_dropped", 32'(frames_dropped), 32'd0);
    reset = 1'b0; tb_load = 1'b0;
    @(posedge clk); #1;
    chk("idle_tvalid", 32'(egress_tvalid), 32'd0);

    // 4-word frame to port 2 followed back-to-back by a 2-word frame
    egress_tready = 1'b1;
    push_frame(4, 2'd2, 1'b0, 1'b0);
    push_frame(2, 2'd0, 1'b0, 1'b0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!egress_tvalid && n < 20);
    chk("first_tvalid_latency", 32'(n), 32'd3);
    ren_cnt = 0; gap = 0; seen_last = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!seen_last) begin
        if (frame_ren) ren_cnt++;
        if (egress_tvalid && egress_tlast) seen_last = 1'b1;
      end else if (!egress_tvalid) gap++;
      else break;
      @(posedge clk); #1;
    end
    chk("frame_ren_pulses", 32'(ren_cnt), 32'd4);
    chk("b2b_gap", 32'(gap), 32'd3);
    drain(1'b0);

    // Permanent stall: four timed-out requests, then rewind
    mon_data_en = 1'b0; egress_tready = 1'b0;
    push_frame(3, 2'd1, 1'b0, 1'b1);
    runs = 0; run_len = 0; gap = 0; prev = 1'b0; got_rrst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (egress_tvalid) begin
        if (!prev && runs > 0) chk("backoff_gap", 32'(gap), 32'd8);
        if (!prev) begin runs++; run_len = 0; end
        run_len++;
      end else begin
        if (prev) begin chk("timeout_len", 32'(run_len), 32'd512); gap = 0; end
        gap++;
      end
      prev = egress_tvalid;
      if (frame_rrst) begin got_rrst = 1'b1; break; end
    end
    chk("timeout_rrst_seen", 32'(got_rrst), 32'd1);
    chk("timeout_runs", 32'(runs), 32'd4);
    drain(1'b0);
    mon_data_en = 1'b1;

    // One timeout, granted on the second request
    egress_tready = 1'b0;
    push_frame(4, 2'd3, 1'b0, 1'b0);
    n = 0;
    while (!egress_tvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("retry_first_req", 32'(egress_tvalid), 32'd1);
    n = 0;
    while (egress_tvalid && n < 600) begin @(posedge clk); #1; n++; end
    chk("retry_timeout", 32'(egress_tvalid), 32'd0);
    egress_tready = 1'b1;
    drain(1'b0);

    // Flagged drop followed by a good frame
    push_frame(3, 2'd1, 1'b1, 1'b0);
    push_frame(3, 2'd1, 1'b0, 1'b0);
    drain(1'b1);

    // Disabled port, then a frame straddling the pointer wrap, then an empty frame
    port_enable = 4'b1011;
    push_frame(3, 2'd2, 1'b0, 1'b0);
    drain(1'b1);
    port_enable = 4'hF;
    wptr = 12'hFFE; tb_load = 1'b1; tb_load_val = wptr;
    @(posedge clk); #1;
    tb_load = 1'b0;
    push_frame(3, 2'd0, 1'b0, 1'b0);
    push_frame(0, 2'd1, 1'b0, 1'b0);
    drain(1'b0);

    // Random batches
    for (int b = 0; b < 4; b++) begin
      port_enable = 4'($urandom);
      for (int f = 0; f < 8; f++)
        push_frame(int'($urandom_range(0, 6)), 2'($urandom), 1'($urandom_range(0, 5) == 0), 1'b0);
      drain(1'b1);
    end

    // Reset in the middle of a long frame under random stalls
    port_enable = 4'hF;
    push_frame(20, 2'd1, 1'b0, 1'b0);
    target = exp_wr - 14;
    n = 0;
    while (exp_rd < target && n < 400) begin
      @(posedge clk); #1;
      egress_tready = ($urandom_range(0, 3) != 0);
      n++;
    end
    chk("midframe_progress", 32'(exp_rd >= target), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tvalid", 32'(egress_tvalid), 32'd0);
    chk("mid_rst_frame_ren", 32'(frame_ren), 32'd0);
    chk("mid_rst_tdata", 32'(egress_tdata), 32'd0);
    chk("mid_rst_sent", 32'(frames_sent), 32'd0);
    chk("mid_rst_dropped", 32'(frames_dropped), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; tb_load = 1'b1; tb_load_val = wptr;
    exp_sent = 0; exp_dropped = 0;
    @(posedge clk); #1;
    tb_load = 1'b0;
    push_frame(5, 2'd3, 1'b0, 1'b0);
    drain(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
